// File: rtl/alarm_sequencer.sv
// -----------------------------------------------------------------------------
// alarm_sequencer
//
// Owns the alarm time registers and sequences ringing for the digital clock:
// button-driven alarm setting, arming from sw0, match detection against the
// running clock, ring timeout, and snooze with a bounded count per event.
//
// Ports
//   clk         system clock
//   rst         asynchronous reset, active-high
//   tick_1hz    one-clk strobe per second, aligned with c_sec update
//   sw0         alarm enable switch (level)
//   btn[3:0]    debounced one-clk pulses:
//               [0] set-mode toggle, [1] hour+1, [2] minute+1, [3] snooze/dismiss
//   c_hour      current hour 0..23
//   c_min       current minute 0..59
//   c_sec       current second 0..59
//   a_hr        programmed alarm hour
//   a_min       programmed alarm minute
//   alarm       buzzer drive
//   ringing     high while in RINGING
//   snooze_cnt  snoozes used in the current alarm event
//   state       FSM state code (IDLE=0 ARMED=1 RINGING=2 SNOOZE=3 SET=4)
//
// Build option
//   ALARM_BEEP_EN  when defined, alarm toggles on every tick_1hz while
//                  ringing (starting high); otherwise alarm is steady high.
// -----------------------------------------------------------------------------
module alarm_sequencer #(
  parameter int RING_SECS  = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       sw0,
  input  logic [3:0] btn,
  input  logic [5:0] c_hour,
  input  logic [5:0] c_min,
  input  logic [5:0] c_sec,
  output logic [5:0] a_hr,
  output logic [5:0] a_min,
  output logic       alarm,
  output logic       ringing,
  output logic [1:0] snooze_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_RINGING = 3'd2,
    S_SNOOZE  = 3'd3,
    S_SET     = 3'd4
  } state_t;

  localparam logic [6:0] SNOOZE_ADD = 7'(SNOOZE_MIN);
  localparam logic [6:0] RING_LIM   = 7'(RING_SECS);
  localparam logic [1:0] SNOOZE_LIM = 2'(MAX_SNOOZE);

  // Modular add of an in-range 6-bit value: 7-bit sum, one conditional subtract.
  function automatic logic [5:0] mod_add(input logic [5:0] a,
                                         input logic [6:0] b,
                                         input logic [6:0] m);
    logic [6:0] sum;
    sum = {1'b0, a} + b;
    if (sum >= m) begin
      return 6'(sum - m);
    end
    return sum[5:0];
  endfunction

  state_t     state_q, state_d;
  logic [5:0] a_hr_q, a_hr_d;
  logic [5:0] a_min_q, a_min_d;
  logic [5:0] tgt_hr_q, tgt_hr_d;
  logic [5:0] tgt_min_q, tgt_min_d;
  logic [1:0] snooze_cnt_q, snooze_cnt_d;
  logic [5:0] ring_timer_q, ring_timer_d;
  logic       alarm_q, alarm_d;
  logic       ringing_q, ringing_d;

  logic [5:0] hr_inc, min_inc;
  logic [5:0] snz_min, snz_hr;
  logic       snz_carry;
  logic [6:0] ring_nxt;
  logic       match, timeout;

  // Arithmetic helpers shared by the next-state logic.
  always_comb begin
    hr_inc    = mod_add(a_hr_q, 7'd1, 7'd24);
    min_inc   = mod_add(a_min_q, 7'd1, 7'd60);
    // Snooze target is based on the live clock, minute overflow carries into hour.
    snz_carry = (({1'b0, c_min} + SNOOZE_ADD) >= 7'd60);
    snz_min   = mod_add(c_min, SNOOZE_ADD, 7'd60);
    snz_hr    = mod_add(c_hour, {6'd0, snz_carry}, 7'd24);
    ring_nxt  = {1'b0, ring_timer_q} + 7'd1;
    // Target is always in range, so an out-of-range clock value cannot match.
    match     = tick_1hz && (c_hour == tgt_hr_q) && (c_min == tgt_min_q) &&
                (c_sec == 6'd0);
    timeout   = tick_1hz && (ring_nxt >= RING_LIM);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    a_hr_d       = a_hr_q;
    a_min_d      = a_min_q;
    tgt_hr_d     = tgt_hr_q;
    tgt_min_d    = tgt_min_q;
    snooze_cnt_d = snooze_cnt_q;
    ring_timer_d = ring_timer_q;

    case (state_q)
      S_IDLE: begin
        if (btn[0]) begin
          state_d = S_SET;
        end else if (sw0) begin
          state_d = S_ARMED;
        end
      end

      S_SET: begin
        // All button bits act in the same cycle; exit latches the new time.
        if (btn[1]) a_hr_d  = hr_inc;
        if (btn[2]) a_min_d = min_inc;
        if (btn[0]) begin
          state_d      = sw0 ? S_ARMED : S_IDLE;
          tgt_hr_d     = a_hr_d;
          tgt_min_d    = a_min_d;
          snooze_cnt_d = 2'd0;
        end
      end

      S_ARMED: begin
        if (!sw0) begin
          state_d = S_IDLE;
        end else if (btn[0]) begin
          state_d = S_SET;
        end else if (match) begin
          state_d      = S_RINGING;
          ring_timer_d = 6'd0;
        end
      end

      S_RINGING: begin
        if (!sw0) begin
          state_d = S_IDLE;
        end else if (btn[3] && (snooze_cnt_q < SNOOZE_LIM)) begin
          // A snooze press wins over a coincident timeout.
          state_d      = S_SNOOZE;
          snooze_cnt_d = 2'(snooze_cnt_q + 2'd1);
          tgt_hr_d     = snz_hr;
          tgt_min_d    = snz_min;
        end else if (btn[3] || timeout) begin
          state_d      = S_ARMED;
          tgt_hr_d     = a_hr_q;
          tgt_min_d    = a_min_q;
          snooze_cnt_d = 2'd0;
        end else if (tick_1hz) begin
          ring_timer_d = ring_nxt[5:0];
        end
      end

      S_SNOOZE: begin
        if (!sw0) begin
          state_d = S_IDLE;
        end else if (btn[3]) begin
          state_d      = S_ARMED;
          tgt_hr_d     = a_hr_q;
          tgt_min_d    = a_min_q;
          snooze_cnt_d = 2'd0;
        end else if (match) begin
          state_d      = S_RINGING;
          ring_timer_d = 6'd0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    ringing_d = (state_d == S_RINGING);
`ifdef ALARM_BEEP_EN
    // Start high on entry, then flip every second while still ringing.
    if (state_d != S_RINGING) begin
      alarm_d = 1'b0;
    end else if (state_q != S_RINGING) begin
      alarm_d = 1'b1;
    end else if (tick_1hz) begin
      alarm_d = ~alarm_q;
    end else begin
      alarm_d = alarm_q;
    end
`else
    alarm_d = (state_d == S_RINGING);
`endif
  end

  // State and output registers; async clear silences the buzzer immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      a_hr_q       <= 6'd12;
      a_min_q      <= 6'd0;
      tgt_hr_q     <= 6'd12;
      tgt_min_q    <= 6'd0;
      snooze_cnt_q <= 2'd0;
      ring_timer_q <= 6'd0;
      alarm_q      <= 1'b0;
      ringing_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_hr_q       <= a_hr_d;
      a_min_q      <= a_min_d;
      tgt_hr_q     <= tgt_hr_d;
      tgt_min_q    <= tgt_min_d;
      snooze_cnt_q <= snooze_cnt_d;
      ring_timer_q <= ring_timer_d;
      alarm_q      <= alarm_d;
      ringing_q    <= ringing_d;
    end
  end

  assign a_hr       = a_hr_q;
  assign a_min      = a_min_q;
  assign alarm      = alarm_q;
  assign ringing    = ringing_q;
  assign snooze_cnt = snooze_cnt_q;
  assign state      = state_q;

endmodule
